// File: rtl/m1_rgb_to_yuv_encoder_if.sv
// ---------------------------------------------------------------------------
// m1_rgb_to_yuv_encoder_if
//
// Single-port SRAM bus shared between the RGB-to-YUV encoder and the memory.
//
//   SRAM_address     18  word address (driven by the encoder)
//   SRAM_read_data   16  read data    (driven by the memory)
//   SRAM_write_data  16  write data   (driven by the encoder)
//   SRAM_we_n         1  write enable, active low (driven by the encoder)
//
// master: the encoder side.  slave: the memory side.
// ---------------------------------------------------------------------------
interface m1_rgb_to_yuv_encoder_if;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    modport master (
        output SRAM_address,
        output SRAM_write_data,
        output SRAM_we_n,
        input  SRAM_read_data
    );

    modport slave (
        input  SRAM_address,
        input  SRAM_write_data,
        input  SRAM_we_n,
        output SRAM_read_data
    );
endinterface

// File: rtl/m1_rgb_to_yuv_encoder.sv
// ---------------------------------------------------------------------------
// m1_rgb_to_yuv_encoder
//
// Reads a frame of packed 8-bit RGB from the shared SRAM and writes it back
// as YUV 4:2:2 into the Y, U and V planes. Each group of 4 pixels takes a
// fixed 13-cycle schedule: 6 reads, 2 drain cycles, 1 compute cycle and
// 4 writes (Y word 0, Y word 1, U word, V word).
//
// Ports:
//   Clock   rising-edge clock
//   Reset   synchronous, active-high reset
//   Enable  start request, only looked at while idle
//   sram    SRAM bus (master side), all outputs registered
//   Done    one-cycle pulse after the last group has been written
//
// The state register names the bus cycle whose outputs are loaded at the
// next edge, so the state that carries a given bus cycle is entered one
// edge before that cycle begins.
// ---------------------------------------------------------------------------
module m1_rgb_to_yuv_encoder #(
    parameter int          NUM_GROUPS = 19200,
    parameter logic [17:0] Y_BASE     = 18'd0,
    parameter logic [17:0] U_BASE     = 18'd38400,
    parameter logic [17:0] V_BASE     = 18'd57600,
    parameter logic [17:0] RGB_BASE   = 18'd146944
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           Enable,
    m1_rgb_to_yuv_encoder_if.master        sram,
    output logic                           Done
);

    localparam int G_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [G_W-1:0] LAST_GROUP = G_W'(NUM_GROUPS - 1);

    typedef enum logic [3:0] {
        IDLE, RD0, RD1, RD2, RD3, RD4, RD5, WT0, WT1, CALC,
        WY0, WY1, WU, WV, DONE
    } state_t;

    state_t          state_reg;
    logic [G_W-1:0]  g_reg;
    logic [17:0]     rgb_addr_reg;
    logic [17:0]     sram_address_reg;
    logic [15:0]     sram_write_data_reg;
    logic            sram_we_n_reg;
    logic            done_reg;

    logic [15:0]     rgb_word_reg [6];
    logic [7:0]      y_reg [4];
    logic [7:0]      u_reg [2];
    logic [7:0]      v_reg [2];

    logic [7:0]      pix_r [4];
    logic [7:0]      pix_g [4];
    logic [7:0]      pix_b [4];
    logic [7:0]      y_next [4];
    logic [7:0]      u_next [2];
    logic [7:0]      v_next [2];

    assign sram.SRAM_address    = sram_address_reg;
    assign sram.SRAM_write_data = sram_write_data_reg;
    assign sram.SRAM_we_n       = sram_we_n_reg;
    assign Done                 = done_reg;

    // Q16 fixed-point result to an 8-bit sample, saturating at both ends.
    function automatic logic [7:0] clip_q16(input int acc);
        int q;
        q = acc >>> 16;
        if (q < 0)
            return 8'd0;
        else if (q > 255)
            return 8'd255;
        else
            return q[7:0];
    endfunction

    function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
        int acc;
        acc = 16843 * int'({24'd0, r}) + 33030 * int'({24'd0, g})
            + 6423 * int'({24'd0, b}) + 1048576 + 32768;
        return clip_q16(acc);
    endfunction

    function automatic logic [7:0] chroma_u(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
        int acc;
        acc = -9699 * int'({24'd0, r}) - 19071 * int'({24'd0, g})
            + 28770 * int'({24'd0, b}) + 8388608 + 32768;
        return clip_q16(acc);
    endfunction

    function automatic logic [7:0] chroma_v(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
        int acc;
        acc = 28770 * int'({24'd0, r}) - 24117 * int'({24'd0, g})
            - 4653 * int'({24'd0, b}) + 8388608 + 32768;
        return clip_q16(acc);
    endfunction

    // Rounded average of two 8-bit components; the 9-bit sum cannot overflow.
    function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction

    // Each pair occupies three words: {R0,G0}, {B0,R1}, {G1,B1}.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign pix_r[2*gi]   = rgb_word_reg[3*gi][15:8];
            assign pix_g[2*gi]   = rgb_word_reg[3*gi][7:0];
            assign pix_b[2*gi]   = rgb_word_reg[3*gi+1][15:8];
            assign pix_r[2*gi+1] = rgb_word_reg[3*gi+1][7:0];
            assign pix_g[2*gi+1] = rgb_word_reg[3*gi+2][15:8];
            assign pix_b[2*gi+1] = rgb_word_reg[3*gi+2][7:0];

            assign u_next[gi] = chroma_u(avg2(pix_r[2*gi], pix_r[2*gi+1]),
                                         avg2(pix_g[2*gi], pix_g[2*gi+1]),
                                         avg2(pix_b[2*gi], pix_b[2*gi+1]));
            assign v_next[gi] = chroma_v(avg2(pix_r[2*gi], pix_r[2*gi+1]),
                                         avg2(pix_g[2*gi], pix_g[2*gi+1]),
                                         avg2(pix_b[2*gi], pix_b[2*gi+1]));
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_luma
            assign y_next[gi] = luma(pix_r[gi], pix_g[gi], pix_b[gi]);
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg           <= IDLE;
            g_reg               <= '0;
            rgb_addr_reg        <= RGB_BASE;
            sram_address_reg    <= 18'd0;
            sram_write_data_reg <= 16'd0;
            sram_we_n_reg       <= 1'b1;
            done_reg            <= 1'b0;
            for (int i = 0; i < 6; i++) rgb_word_reg[i] <= 16'd0;
            for (int i = 0; i < 4; i++) y_reg[i] <= 8'd0;
            for (int i = 0; i < 2; i++) begin
                u_reg[i] <= 8'd0;
                v_reg[i] <= 8'd0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    sram_we_n_reg <= 1'b1;
                    done_reg      <= 1'b0;
                    if (Enable) begin
                        g_reg        <= '0;
                        rgb_addr_reg <= RGB_BASE;
                        state_reg    <= RD0;
                    end
                end

                // Reads: the RGB pointer simply walks 6 words per group, so
                // no multiply by 6 is needed.
                RD0, RD1, RD2, RD3, RD4, RD5: begin
                    sram_address_reg <= rgb_addr_reg;
                    rgb_addr_reg     <= rgb_addr_reg + 18'd1;
                    sram_we_n_reg    <= 1'b1;
                    // Two-cycle read latency: word k arrives while the read
                    // for word k+3 is being issued.
                    case (state_reg)
                        RD3:     rgb_word_reg[0] <= sram.SRAM_read_data;
                        RD4:     rgb_word_reg[1] <= sram.SRAM_read_data;
                        RD5:     rgb_word_reg[2] <= sram.SRAM_read_data;
                        default: ;
                    endcase
                    state_reg <= state_t'(state_reg + 4'd1);
                end

                WT0: begin
                    sram_we_n_reg   <= 1'b1;
                    rgb_word_reg[3] <= sram.SRAM_read_data;
                    state_reg       <= WT1;
                end

                WT1: begin
                    sram_we_n_reg   <= 1'b1;
                    rgb_word_reg[4] <= sram.SRAM_read_data;
                    state_reg       <= CALC;
                end

                CALC: begin
                    sram_we_n_reg   <= 1'b1;
                    rgb_word_reg[5] <= sram.SRAM_read_data;
                    state_reg       <= WY0;
                end

                // Results are captured here and the first Y word goes out on
                // the same edge straight from the combinational datapath.
                WY0: begin
                    for (int i = 0; i < 4; i++) y_reg[i] <= y_next[i];
                    for (int i = 0; i < 2; i++) begin
                        u_reg[i] <= u_next[i];
                        v_reg[i] <= v_next[i];
                    end
                    sram_address_reg    <= Y_BASE + 18'({g_reg, 1'b0});
                    sram_write_data_reg <= {y_next[0], y_next[1]};
                    sram_we_n_reg       <= 1'b0;
                    state_reg           <= WY1;
                end

                WY1: begin
                    sram_address_reg    <= Y_BASE + 18'({g_reg, 1'b1});
                    sram_write_data_reg <= {y_reg[2], y_reg[3]};
                    sram_we_n_reg       <= 1'b0;
                    state_reg           <= WU;
                end

                WU: begin
                    sram_address_reg    <= U_BASE + 18'(g_reg);
                    sram_write_data_reg <= {u_reg[0], u_reg[1]};
                    sram_we_n_reg       <= 1'b0;
                    state_reg           <= WV;
                end

                WV: begin
                    sram_address_reg    <= V_BASE + 18'(g_reg);
                    sram_write_data_reg <= {v_reg[0], v_reg[1]};
                    sram_we_n_reg       <= 1'b0;
                    if (g_reg == LAST_GROUP) begin
                        g_reg     <= '0;
                        state_reg <= DONE;
                    end else begin
                        g_reg     <= g_reg + 1'b1;
                        state_reg <= RD0;
                    end
                end

                DONE: begin
                    sram_we_n_reg <= 1'b1;
                    done_reg      <= 1'b1;
                    rgb_addr_reg  <= RGB_BASE;
                    state_reg     <= IDLE;
                end

                default: begin
                    sram_we_n_reg <= 1'b1;
                    done_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m1_rgb_to_yuv_encoder.sv
// ---------------------------------------------------------------------------
// tb_m1_rgb_to_yuv_encoder
//
// Self-checking bench for the RGB-to-YUV encoder with a 2-group frame.
// A behavioural SRAM (two-cycle read latency) is serviced on every falling
// edge; every DUT write is popped against an expected-write queue filled
// when the RGB stimulus is loaded.
// ---------------------------------------------------------------------------
module tb_m1_rgb_to_yuv_encoder;

    localparam int          NG = 2;
    localparam logic [17:0] YB = 18'd0;
    localparam logic [17:0] UB = 18'd38400;
    localparam logic [17:0] VB = 18'd57600;
    localparam logic [17:0] RB = 18'd146944;

    logic Clock  = 1'b0;
    logic Reset  = 1'b0;
    logic Enable = 1'b0;
    logic Done;

    m1_rgb_to_yuv_encoder_if bus ();

    m1_rgb_to_yuv_encoder #(
        .NUM_GROUPS (NG),
        .Y_BASE     (YB),
        .U_BASE     (UB),
        .V_BASE     (VB),
        .RGB_BASE   (RB)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (Enable),
        .sram   (bus),
        .Done   (Done)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        string       name;
        logic [15:0] w [6];
        logic [15:0] y0;
        logic [15:0] y1;
        logic [15:0] u;
        logic [15:0] v;
    } vec_t;

    logic [15:0] mem [0:262143];
    logic [15:0] pipe1;
    logic [15:0] pipe2;
    wr_t         exp_q [$];
    vec_t        tbl [4];

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // One clock: sample DUT on the falling edge, check any write, then
    // advance the SRAM model (data for a cycle-t address is presented
    // during cycle t+2).
    task automatic tick();
        wr_t e;
        @(negedge Clock);
        cyc++;
        if (Done === 1'b1) done_cnt++;
        if (bus.SRAM_we_n === 1'b0) begin
            mem[bus.SRAM_address] = bus.SRAM_write_data;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%h", bus.SRAM_address,
                         bus.SRAM_write_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.SRAM_address !== e.addr || bus.SRAM_write_data !== e.data) begin
                    bad++;
                    $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                             bus.SRAM_address, bus.SRAM_write_data, e.addr, e.data);
                end else begin
                    $display("write addr=%0d data=%h ok", e.addr, e.data);
                end
            end
        end
        bus.SRAM_read_data = pipe2;
        pipe2 = pipe1;
        pipe1 = mem[bus.SRAM_address];
    endtask

    function automatic logic [7:0] m_clip(input int acc);
        int q;
        q = acc >>> 16;
        if (q < 0) return 8'd0;
        if (q > 255) return 8'd255;
        return 8'(q);
    endfunction

    function automatic logic [7:0] m_avg(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = (int'(a) + int'(b) + 1) / 2;
        return 8'(s);
    endfunction

    task automatic push_exp(input int g, input logic [15:0] y0, input logic [15:0] y1,
                            input logic [15:0] u, input logic [15:0] v);
        exp_q.push_back('{addr: YB + 18'(2*g),     data: y0});
        exp_q.push_back('{addr: YB + 18'(2*g + 1), data: y1});
        exp_q.push_back('{addr: UB + 18'(g),       data: u});
        exp_q.push_back('{addr: VB + 18'(g),       data: v});
    endtask

    task automatic load_group(input int g, input logic [15:0] w [6]);
        for (int j = 0; j < 6; j++) mem[RB + 18'(6*g + j)] = w[j];
    endtask

    // Reference model: unpack, convert, and queue the four expected writes.
    task automatic model_group(input int g, input logic [15:0] w [6]);
        logic [7:0] r [4];
        logic [7:0] gc [4];
        logic [7:0] b [4];
        logic [7:0] y [4];
        logic [7:0] u [2];
        logic [7:0] v [2];
        logic [7:0] ra, ga, ba;
        for (int p = 0; p < 2; p++) begin
            r[2*p]    = w[3*p][15:8];
            gc[2*p]   = w[3*p][7:0];
            b[2*p]    = w[3*p+1][15:8];
            r[2*p+1]  = w[3*p+1][7:0];
            gc[2*p+1] = w[3*p+2][15:8];
            b[2*p+1]  = w[3*p+2][7:0];
        end
        for (int i = 0; i < 4; i++)
            y[i] = m_clip(16843*int'(r[i]) + 33030*int'(gc[i]) + 6423*int'(b[i]) + 1081344);
        for (int p = 0; p < 2; p++) begin
            ra = m_avg(r[2*p], r[2*p+1]);
            ga = m_avg(gc[2*p], gc[2*p+1]);
            ba = m_avg(b[2*p], b[2*p+1]);
            u[p] = m_clip(-9699*int'(ra) - 19071*int'(ga) + 28770*int'(ba) + 8421376);
            v[p] = m_clip(28770*int'(ra) - 24117*int'(ga) - 4653*int'(ba) + 8421376);
        end
        push_exp(g, {y[0], y[1]}, {y[2], y[3]}, {u[0], u[1]}, {v[0], v[1]});
    endtask

    // Load table entries a (group 0) and b (group 1) with their fixed results.
    task automatic load_table_frame(input int a, input int b);
        load_group(0, tbl[a].w);
        push_exp(0, tbl[a].y0, tbl[a].y1, tbl[a].u, tbl[a].v);
        load_group(1, tbl[b].w);
        push_exp(1, tbl[b].y0, tbl[b].y1, tbl[b].u, tbl[b].v);
    endtask

    task automatic run_frame(input string tag, input bit hold_en);
        int  d0;
        bit  seen;
        d0   = done_cnt;
        seen = 1'b0;
        Enable = 1'b1;
        tick();
        if (!hold_en) Enable = 1'b0;
        for (int k = 1; k <= 13*NG + 40; k++) begin
            tick();
            if (k == 1) chk({tag, "_first_addr"}, 32'(bus.SRAM_address), 32'(RB));
            if (Done === 1'b1) begin
                seen = 1'b1;
                chk({tag, "_done_cycle"}, 32'(k), 32'(13*NG + 1));
                break;
            end
        end
        Enable = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_done_timeout got=no_done want=done", tag);
        end
        tick();
        chk({tag, "_done_len"}, 32'(Done), 32'd0);
        chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        $display("frame %s complete at cycle %0d", tag, cyc);
    endtask

    initial begin
        logic [15:0] rw [6];
        int d0;

        tbl[0].name = "white";
        tbl[0].w    = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[0].y0 = 16'hEBEB; tbl[0].y1 = 16'hEBEB; tbl[0].u = 16'h8080; tbl[0].v = 16'h8080;
        tbl[1].name = "black";
        tbl[1].w    = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[1].y0 = 16'h1010; tbl[1].y1 = 16'h1010; tbl[1].u = 16'h8080; tbl[1].v = 16'h8080;
        tbl[2].name = "avg_red0";
        tbl[2].w    = '{16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[2].y0 = 16'h5210; tbl[2].y1 = 16'h1010; tbl[2].u = 16'h6D80; tbl[2].v = 16'hB880;
        tbl[3].name = "red_pair";
        tbl[3].w    = '{16'hFF00, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[3].y0 = 16'h5252; tbl[3].y1 = 16'h1010; tbl[3].u = 16'h5A80; tbl[3].v = 16'hF080;

        pipe1 = 16'd0;
        pipe2 = 16'd0;
        bus.SRAM_read_data = 16'd0;

        // Reset asserted mid-cycle, then released.
        #2 Reset = 1'b1;
        repeat (3) tick();
        chk("rst_addr", 32'(bus.SRAM_address), 32'd0);
        chk("rst_wdata", 32'(bus.SRAM_write_data), 32'd0);
        chk("rst_we_n", 32'(bus.SRAM_we_n), 32'd1);
        chk("rst_done", 32'(Done), 32'd0);
        Reset = 1'b0;
        repeat (2) tick();
        chk("idle_we_n", 32'(bus.SRAM_we_n), 32'd1);
        chk("idle_addr", 32'(bus.SRAM_address), 32'd0);

        // Table-driven frames: group 0 = entry i, group 1 = the next entry.
        for (int i = 0; i < 4; i++) begin
            load_table_frame(i, (i + 1) % 4);
            run_frame(tbl[i].name, 1'b0);
            repeat (2) tick();
        end

        // Random pixel frames checked against the reference model.
        for (int f = 0; f < 3; f++) begin
            for (int g = 0; g < NG; g++) begin
                for (int j = 0; j < 6; j++) rw[j] = 16'($urandom);
                load_group(g, rw);
                model_group(g, rw);
            end
            run_frame($sformatf("rand%0d", f), 1'b0);
            tick();
        end

        // Enable held for the whole frame: one frame, one Done, no restart.
        load_table_frame(3, 2);
        run_frame("hold_en", 1'b1);
        d0 = done_cnt;
        repeat (40) tick();
        chk("hold_no_second_done", 32'(done_cnt - d0), 32'd0);
        chk("hold_idle_we_n", 32'(bus.SRAM_we_n), 32'd1);

        // Reset during group 1, offset 10 (bus cycle 24: Y word 1 write).
        load_table_frame(2, 0);
        Enable = 1'b1;
        tick();
        Enable = 1'b0;
        for (int k = 1; k <= 24; k++) tick();
        chk("mid_rst_pending_writes", 32'(exp_q.size()), 32'd2);
        Reset = 1'b1;
        exp_q.delete();
        tick();
        chk("mid_rst_we_n", 32'(bus.SRAM_we_n), 32'd1);
        chk("mid_rst_addr", 32'(bus.SRAM_address), 32'd0);
        repeat (5) tick();
        Reset = 1'b0;
        repeat (3) tick();
        chk("mid_rst_no_done", 32'(Done), 32'd0);

        // Restart from group 0 with the same data.
        load_table_frame(2, 0);
        run_frame("restart", 1'b0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
